// File: rtl/xs3_pkg.sv
// ============================================================================
// xs3_pkg : excess-3 code constants and adder FSM state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package xs3_pkg;

    localparam logic [3:0] XS3_BIAS = 4'd3;
    localparam logic [3:0] XS3_MIN  = 4'd3;
    localparam logic [3:0] XS3_MAX  = 4'd12;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    function automatic logic xs3_is_invalid(input logic [3:0] d);
        return (d < XS3_MIN) || (d > XS3_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/xs3_digit_add.sv
// ============================================================================
// xs3_digit_add : one excess-3 digit add with bias correction and code check
// Rev 1.0
// ============================================================================
`default_nettype none

module xs3_digit_add
    import xs3_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout,
    output logic       invalid
);

    logic [4:0] w_sum;

    assign w_sum   = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign invalid = xs3_is_invalid(a) | xs3_is_invalid(b);

    // Two biases sit in the raw sum: a decimal carry shows up as a binary
    // carry, after which the bias must be restored rather than removed.
    always_comb begin
        digit = w_sum[3:0] - XS3_BIAS;
        cout  = 1'b0;
        if (w_sum[4]) begin
            digit = w_sum[3:0] + XS3_BIAS;
            cout  = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/xs3_serial_adder.sv
// ============================================================================
// xs3_serial_adder : digit-serial (LSD first) excess-3 adder, valid/ready I/O
// Rev 1.0
// ============================================================================
`default_nettype none

module xs3_serial_adder
    import xs3_pkg::*;
#(
    parameter int NDIG = 4
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a_xs3,
    input  logic [3:0] b_xs3,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] sum_xs3,
    output logic       out_last,
    output logic       carry_out,
    output logic       err
);

    localparam int              CW     = $clog2(NDIG);
    localparam logic [CW-1:0]   C_LAST = CW'(NDIG - 1);

    state_t          state_q,     state_d;
    logic [CW-1:0]   count_q,     count_d;
    logic            carry_q,     carry_d;
    logic            err_acc_q,   err_acc_d;
    logic            out_valid_q, out_valid_d;
    logic [3:0]      sum_q,       sum_d;
    logic            out_last_q,  out_last_d;
    logic            carry_out_q, carry_out_d;
    logic            err_q,       err_d;

    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_cin;
    logic [3:0]      w_digit;
    logic            w_cout;
    logic            w_invalid;

    assign in_ready   = ~out_valid_q | out_ready;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid_q & out_ready;
    assign w_cin      = (state_q == ST_RUN) ? carry_q : 1'b0;

    xs3_digit_add u_digit_add (
        .a       (a_xs3),
        .b       (b_xs3),
        .cin     (w_cin),
        .digit   (w_digit),
        .cout    (w_cout),
        .invalid (w_invalid)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        carry_d     = carry_q;
        err_acc_d   = err_acc_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        out_last_d  = out_last_q;
        carry_out_d = carry_out_q;
        err_d       = err_q;

        if (w_in_fire) begin
            out_valid_d = 1'b1;
            sum_d       = w_digit;
            if (count_q == C_LAST) begin
                // MSD: publish operand-level status and rearm for next operand
                state_d     = ST_IDLE;
                count_d     = '0;
                carry_d     = 1'b0;
                err_acc_d   = 1'b0;
                out_last_d  = 1'b1;
                carry_out_d = w_cout;
                err_d       = err_acc_q | w_invalid;
            end else begin
                state_d     = ST_RUN;
                count_d     = count_q + 1'b1;
                carry_d     = w_cout;
                err_acc_d   = err_acc_q | w_invalid;
                out_last_d  = 1'b0;
                carry_out_d = 1'b0;
                err_d       = 1'b0;
            end
        end else if (w_out_fire) begin
            out_valid_d = 1'b0;
            sum_d       = '0;
            out_last_d  = 1'b0;
            carry_out_d = 1'b0;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            carry_q     <= 1'b0;
            err_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            out_last_q  <= 1'b0;
            carry_out_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            err_acc_q   <= err_acc_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            out_last_q  <= out_last_d;
            carry_out_q <= carry_out_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum_xs3   = sum_q;
    assign out_last  = out_last_q;
    assign carry_out = carry_out_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_xs3_serial_adder.sv
// ============================================================================
// tb_xs3_serial_adder : vector table, backpressure/reset sequences, random sums
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_xs3_serial_adder;

    localparam int NDIG = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a_xs3;
    logic [3:0] b_xs3;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] sum_xs3;
    logic       out_last;
    logic       carry_out;
    logic       err;

    int checks = 0;
    int errors = 0;

    xs3_serial_adder #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_xs3     (a_xs3),
        .b_xs3     (b_xs3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_xs3   (sum_xs3),
        .out_last  (out_last),
        .carry_out (carry_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Nibble i of each word is digit i (LSD in bits 3:0)
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic        c;
        logic        e;
    } vec_t;

    typedef struct {
        logic [3:0] sum;
        logic       last;
        logic       cout;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    bit         rand_rdy = 1'b0;
    bit         stall_pend = 1'b0;
    logic [3:0] hold_sum;
    logic       hold_last, hold_c, hold_e;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (in_ready !== (~out_valid | out_ready)) begin
                errors++;
                $display("FAIL in_ready_eq: got %b expected %b", in_ready, ~out_valid | out_ready);
            end
            if (stall_pend) begin
                checks++;
                if (out_valid !== 1'b1 || sum_xs3 !== hold_sum || out_last !== hold_last ||
                    carry_out !== hold_c || err !== hold_e) begin
                    errors++;
                    $display("FAIL hold: got v=%b s=%0d l=%b c=%b e=%b expected v=1 s=%0d l=%b c=%b e=%b",
                             out_valid, sum_xs3, out_last, carry_out, err,
                             hold_sum, hold_last, hold_c, hold_e);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_digit: got s=%0d with no digit expected", sum_xs3);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (sum_xs3 !== mon_e.sum || out_last !== mon_e.last ||
                        carry_out !== mon_e.cout || err !== mon_e.err) begin
                        errors++;
                        $display("FAIL digit: got s=%0d l=%b c=%b e=%b expected s=%0d l=%b c=%b e=%b",
                                 sum_xs3, out_last, carry_out, err,
                                 mon_e.sum, mon_e.last, mon_e.cout, mon_e.err);
                    end
                end
            end
            stall_pend = (out_valid === 1'b1) && (out_ready === 1'b0);
            hold_sum   = sum_xs3;
            hold_last  = out_last;
            hold_c     = carry_out;
            hold_e     = err;
        end else begin
            stall_pend = 1'b0;
        end
    end

    // Called between a rising edge and the following falling edge
    task automatic send(input logic [3:0] a, input logic [3:0] b);
        int n;
        a_xs3    = a;
        b_xs3    = b;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL in_timeout: got in_ready=%b expected 1 within 100 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] s, input logic c, input logic e);
        exp_t x;
        for (int i = 0; i < NDIG; i++) begin
            x.sum  = s[4*i +: 4];
            x.last = (i == NDIG - 1);
            x.cout = (i == NDIG - 1) ? c : 1'b0;
            x.err  = (i == NDIG - 1) ? e : 1'b0;
            exp_q.push_back(x);
        end
    endtask

    task automatic apply(input vec_t v, input bit gaps);
        push_exp(v.s, v.c, v.e);
        for (int i = 0; i < NDIG; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send(v.a[4*i +: 4], v.b[4*i +: 4]);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic logic [15:0] to_xs3(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(t % 10 + 3);
            t = t / 10;
        end
        return r;
    endfunction

    vec_t vecs[10];
    vec_t rv;

    initial begin
        //                A         B         S        c     e
        vecs[0] = '{16'h4567, 16'h89AB, 16'h9C45, 1'b0, 1'b0}; // 1234+5678
        vecs[1] = '{16'hCCCC, 16'h3334, 16'h3333, 1'b1, 1'b0}; // 9999+0001
        vecs[2] = '{16'h3333, 16'h3333, 16'h3333, 1'b0, 1'b0}; // 0000+0000
        vecs[3] = '{16'h8333, 16'h8333, 16'h3333, 1'b1, 1'b0}; // 5000+5000
        vecs[4] = '{16'h7654, 16'h4444, 16'h8765, 1'b0, 1'b0}; // 4321+1111
        vecs[5] = '{16'h3CCC, 16'h3334, 16'h4333, 1'b0, 1'b0}; // 0999+0001
        vecs[6] = '{16'h45F7, 16'h89AB, 16'h9CD5, 1'b0, 1'b1}; // digit 1 of A = 15
        vecs[7] = '{16'h4567, 16'h89AB, 16'h9C45, 1'b0, 1'b0}; // error must not stick
        vecs[8] = '{16'h0000, 16'h0000, 16'hDDDD, 1'b0, 1'b1}; // all-zero codes
        vecs[9] = '{16'hCCCC, 16'hCCCC, 16'hCCCB, 1'b1, 1'b0}; // 9999+9999

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_xs3     = 4'd0;
        b_xs3     = 4'd0;

        #12;
        check1("rst_out_valid", out_valid, 1'b0);
        check4("rst_sum",       sum_xs3,   4'd0);
        check1("rst_out_last",  out_last,  1'b0);
        check1("rst_carry_out", carry_out, 1'b0);
        check1("rst_err",       err,       1'b0);
        check1("rst_in_ready",  in_ready,  1'b1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check1("post_rst_in_ready", in_ready, 1'b1);

        foreach (vecs[i]) apply(vecs[i], 1'b0);

        // Three-cycle output stall in the middle of 1234+5678
        fork
            apply(vecs[0], 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                check1("stall_in_ready", in_ready, 1'b0);
                check1("stall_out_valid", out_valid, 1'b1);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join

        // Reset after two accepted digits, then a clean operand
        push_exp(16'h0045, 1'b0, 1'b0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        send(4'd7, 4'd11);
        send(4'd6, 4'd10);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check1("mid_rst_out_valid", out_valid, 1'b0);
        check4("mid_rst_sum",       sum_xs3,   4'd0);
        check1("mid_rst_out_last",  out_last,  1'b0);
        check1("mid_rst_in_ready",  in_ready,  1'b1);
        exp_q.delete();
        @(negedge clk);
        check1("in_rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        apply(vecs[0], 1'b0);

        // Random decimal operands with input gaps and random backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            int av, bv, sv;
            av   = $urandom_range(0, 9999);
            bv   = $urandom_range(0, 9999);
            sv   = av + bv;
            rv.a = to_xs3(av);
            rv.b = to_xs3(bv);
            rv.s = to_xs3(sv % 10000);
            rv.c = (sv >= 10000);
            rv.e = 1'b0;
            apply(rv, 1'b1);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d digits outstanding expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/xs3_serial_adder.md
XS3_SERIAL_ADDER -- requirements
Module: xs3_serial_adder

Interface
REQ-001 Parameter NDIG, default 4: number of excess-3 digits per operand, 2..16.
REQ-002 clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  a digit pair is present on a_xs3/b_xs3.
REQ-005 in_ready  output  1  block accepts the pair this cycle.
REQ-006 a_xs3  input  4  operand A digit, XS3 code, LSD first.
REQ-007 b_xs3  input  4  operand B digit, XS3 code, LSD first.
REQ-008 out_valid  output  1  sum digit is present.
REQ-009 out_ready  input  1  downstream takes the sum digit this cycle.
REQ-010 sum_xs3  output  4  sum digit, XS3 code.
REQ-011 out_last  output  1  sum digit is the MSD (digit NDIG-1) of the operand.
REQ-012 carry_out  output  1  final decimal carry; meaningful only when out_last=1, else 0.
REQ-013 err  output  1  at least one digit of this operand was outside 3..12; meaningful only when out_last=1, else 0.

Function
REQ-014 An input transfer occurs when in_valid=1 and in_ready=1; an output transfer occurs when out_valid=1 and out_ready=1.
REQ-015 in_ready SHALL equal (~out_valid | out_ready); no combinational path from in_valid to in_ready.
REQ-016 Per digit: s = a_xs3 + b_xs3 + c (5-bit), c = internal carry; if s >= 16 then digit = s[3:0] + 3, next c = 1; else digit = s[3:0] - 3, next c = 0 (4-bit modulo arithmetic).
REQ-017 The result of an accepted digit appears on sum_xs3 with out_valid=1 on the next cycle (latency 1).
REQ-018 out_valid, sum_xs3, out_last, carry_out and err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 Simultaneous output and input transfer in one cycle SHALL load the new digit with no bubble (full throughput, 1 digit/cycle).
REQ-020 FSM states: IDLE (digit count 0, c=0) and RUN (count 1..NDIG-1); an input transfer in IDLE moves to RUN; in RUN it increments count; the transfer at count NDIG-1 asserts out_last with the result and returns to IDLE with count=0, c=0, error flag cleared.
REQ-021 With out_last, carry_out = carry generated by the MSD; err = sticky OR of invalid-code flags across all NDIG digits of the operand.
REQ-022 Invalid codes (0..2, 13..15) SHALL still be summed per REQ-016; only err reports them.
REQ-023 Without an input transfer, count, c and the error flag SHALL not change.

Reset
REQ-024 rst_n=0 SHALL immediately force out_valid=0, sum_xs3=0, out_last=0, carry_out=0, err=0, count=0, c=0, error flag=0, FSM=IDLE.
REQ-025 Reset mid-operand discards the partial operand; the next accepted digit after release is treated as digit 0 with c=0.
REQ-026 in_ready SHALL be 1 during and immediately after reset.

Structure
REQ-027 Package xs3_pkg SHALL hold XS3_BIAS=3, XS3_MIN=3, XS3_MAX=12 and the FSM state typedef (IDLE, RUN).
REQ-028 One combinational sub-module xs3_digit_add (a, b, cin -> digit, cout, invalid) SHALL implement REQ-016 and code checking; the top holds FSM, counter, carry, sticky error and output register.

Verification
REQ-029 NDIG=4, 1234+5678: A = 7,6,5,4, B = 11,10,9,8 back-to-back, out_ready=1 -> sum_xs3 = 5,4,12,9 on consecutive cycles, out_last on 4th, carry_out=0, err=0.
REQ-030 9999+0001: A = 12,12,12,12, B = 4,3,3,3 -> sum_xs3 = 3,3,3,3, carry_out=1 on out_last.
REQ-031 Backpressure: out_ready=0 for 3 cycles mid-operand -> in_ready=0, outputs frozen, no digit lost or duplicated; final sum matches REQ-029.
REQ-032 Invalid code: A digit 1 = 15 (4'b1111) in a 4-digit operand -> err=1 only with out_last; next valid operand reports err=0.
REQ-033 rst_n pulsed low after 2 accepted digits -> outputs 0 immediately; subsequent 1234+5678 sequence yields REQ-029 result.
REQ-034 Random check: 1000 random valid NDIG-digit operand pairs with random in_valid/out_ready gaps against a decimal reference model.
